tff_bank: RTL

Parametrised multi-channel toggle register: WIDTH T-type flip-flops sharing one clock, with a global mode that selects hold, per-bit toggle, parallel load, or a cascaded T-chain that counts. It also reports which bits changed, a chain wrap-around carry, and a saturating count of active cycles. It replaces single-bit T flip-flop instances wherever a datapath needs a toggle bank, a divider or a small event counter.

---
 rtl/tff_pkg.sv | 7 +
 rtl/tff_cell.sv | 14 +
 rtl/tff_bank.sv | 63 ++++++
 3 files changed

// File: rtl/tff_pkg.sv
// tff_pkg: mode encodings shared by the toggle bank and its bench
package tff_pkg;
    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_LOAD   = 2'b10;
    localparam logic [1:0] MODE_CHAIN  = 2'b11;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: single T flip-flop with async reset to a supplied value and sync load
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic tog,
    input  logic load,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= rst_val;
        else     q <= load ? d : q ^ tog;
endmodule

// File: rtl/tff_bank.sv
// tff_bank: WIDTH-channel T flip-flop bank with hold/toggle/load/chain modes,
// change flags, chain carry and a saturating event counter
module tff_bank
    import tff_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter int              CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] chg,
    output logic             carry,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             evt_sat
);
    logic [WIDTH-1:0] chain, tog, q_n;
    logic             ld, run;
    logic [CNT_W-1:0] cnt_n;
    // ripple enable: bit k toggles when t[0] and all lower bits are ones
    always_comb begin
        run   = t[0];
        chain = '0;
        for (int k = 0; k < WIDTH; k++) begin
            chain[k] = run;
            run      = run & q[k];
        end
    end
    assign tog   = !en ? '0 : mode == MODE_TOGGLE ? t : mode == MODE_CHAIN ? chain : '0;
    assign ld    = en && mode == MODE_LOAD;
    assign q_n   = ld ? d : q ^ tog;
    assign cnt_n = cnt_clr ? '0 : (|(q_n ^ q) && !(&evt_cnt)) ? evt_cnt + CNT_W'(1) : evt_cnt;
    genvar i;
    for (i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .rst_val(RST_VAL[i]),
            .tog    (tog[i]),
            .load   (ld),
            .d      (d[i]),
            .q      (q[i])
        );
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            chg     <= '0;
            carry   <= 1'b0;
            evt_cnt <= '0;
            evt_sat <= 1'b0;
        end else begin
            chg     <= q_n ^ q;
            carry   <= en && mode == MODE_CHAIN && t[0] && &q;
            evt_cnt <= cnt_n;
            evt_sat <= &cnt_n;
        end
endmodule
